// File: rtl/iot_feeder_pkg.sv
// Shared widths and types for the IOTDF byte feeder.
// Defaults match the IOTDF 128-bit sample / 8-bit iot_in interface.
package iot_feeder_pkg;

  localparam int WORD_W = 128;
  localparam int BYTE_W = 8;
  localparam int DEPTH = 2;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  typedef logic [BYTE_W-1:0] byte_lane_t;
  typedef logic [IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/iot_word_fifo.sv
// Register FIFO of whole sample words; head is read combinationally.
// Full/empty come from one extra pointer bit beyond the address.
module iot_word_fifo
  import iot_feeder_pkg::*;
#(
  parameter int W = 128,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(N);

  logic [W-1:0] mem_q [N];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;
  logic         do_push, do_pop;

  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = (wp_q == rp_q);
  assign rdata = mem_q[rp_q[AW-1:0]];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (clear) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage needs no reset: it is never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/iot_byte_feeder.sv
// Buffers 128-bit samples and feeds them MSB byte first to IOTDF.
// Output register is a valid/ready stage whose ready is !busy.
module iot_byte_feeder
  import iot_feeder_pkg::*;
#(
  parameter int WORD_W = iot_feeder_pkg::WORD_W,
  parameter int BYTE_W = iot_feeder_pkg::BYTE_W,
  parameter int DEPTH  = iot_feeder_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              busy,
  output logic              in_en,
  output logic [BYTE_W-1:0] iot_in,
  output logic [15:0]       sent_words,
  output logic              idle
);

  localparam int BPW = WORD_W / BYTE_W;
  localparam int IW = $clog2(BPW);
  localparam logic [IW-1:0] LAST = IW'(BPW - 1);

  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] head;
  logic              push, pop, take, at_last;
  logic [IW-1:0]     lane_sel;
  logic [BPW-1:0][BYTE_W-1:0] lanes;

  logic [IW-1:0]     idx_q, idx_d;
  logic              in_en_q, in_en_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic [15:0]       sent_q, sent_d;

  assign lanes    = head;
  assign lane_sel = LAST - idx_q;
  assign at_last  = (idx_q == LAST);
  assign take     = !in_en_q || !busy;
  assign push     = s_valid && !fifo_full && !flush;
  assign pop      = take && !fifo_empty && at_last && !flush;

  iot_word_fifo #(
    .W (WORD_W),
    .N (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clear (flush),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    idx_d   = idx_q;
    in_en_d = in_en_q;
    byte_d  = byte_q;
    last_d  = last_q;
    sent_d  = sent_q;
    // A byte consumed at the flush edge still completes its word.
    if (in_en_q && !busy && last_q) sent_d = sent_q + 16'd1;
    if (flush) begin
      idx_d   = '0;
      in_en_d = 1'b0;
      byte_d  = '0;
      last_d  = 1'b0;
    end else if (take) begin
      if (!fifo_empty) begin
        in_en_d = 1'b1;
        byte_d  = lanes[lane_sel];
        last_d  = at_last;
        idx_d   = at_last ? '0 : idx_q + 1'b1;
      end else begin
        in_en_d = 1'b0;
        byte_d  = '0;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      in_en_q <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      sent_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      in_en_q <= in_en_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      sent_q  <= sent_d;
    end
  end

  assign s_ready    = !fifo_full;
  assign in_en      = in_en_q;
  assign iot_in     = byte_q;
  assign sent_words = sent_q;
  assign idle       = fifo_empty && !in_en_q;

endmodule

// File: tb/tb_iot_byte_feeder.sv
// Random and directed stimulus for iot_byte_feeder against a
// byte-stream scoreboard model of the feeder.
module tb_iot_byte_feeder;
  import iot_feeder_pkg::*;

  localparam int BPW = BYTES_PER_WORD;
  localparam logic [WORD_W-1:0] W1 =
    128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic              clk = 1'b0;
  logic              rst, flush, s_valid, s_ready, busy;
  logic              in_en, idle;
  logic [WORD_W-1:0] s_data;
  logic [BYTE_W-1:0] iot_in;
  logic [15:0]       sent_words;

  always #5 clk = ~clk;

  iot_byte_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .busy       (busy),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .sent_words (sent_words),
    .idle       (idle)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [BYTE_W-1:0] exp_q[$];
  logic [WORD_W-1:0] src_q[$];
  logic exp_in_en;
  int   pos, exp_sent;
  bit   use_src;
  int   mode, hcnt, base, pulsed, npulse;
  int   cyc_no, n_en, first_en, last_en, n_cons, saw_nr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_in_en = 1'b0;
    pos = 0;
    exp_sent = 0;
  endtask

  task automatic reset_checks();
    check("rst_in_en", in_en, 0);
    check("rst_iot_in", iot_in, 0);
    check("rst_sent", sent_words, 0);
    check("rst_idle", idle, 1);
    check("rst_s_ready", s_ready, 1);
  endtask

  task automatic clr_stats();
    n_en = 0;
    first_en = -1;
    last_en = -1;
    n_cons = 0;
    saw_nr = 0;
  endtask

  task automatic cyc();
    logic acc, cons, fl, bz, ein;
    logic [WORD_W-1:0] d;
    logic [BYTE_W-1:0] b;
    int fb, widx, words;
    if (use_src) begin
      s_valid = (src_q.size() != 0);
      s_data  = s_valid ? src_q[0] : '0;
    end
    widx = exp_sent - base;
    case (mode)
      1: begin
        busy = exp_in_en && pos == 7 && hcnt < 5;
        if (busy) hcnt++;
      end
      2: begin
        busy = exp_in_en && widx < BPW &&
               pos == BPW - 1 - widx && pulsed != widx;
        if (busy) begin
          pulsed = widx;
          npulse++;
        end
      end
      3: busy = ($urandom_range(0, 9) < 3);
      default: busy = 1'b0;
    endcase
    #1;
    acc  = s_valid && s_ready;
    cons = in_en && !busy;
    fl   = flush;
    bz   = busy;
    d    = s_data;
    b    = iot_in;
    if (in_en) begin
      n_en++;
      if (first_en < 0) first_en = cyc_no;
      last_en = cyc_no;
    end
    if (!s_ready) saw_nr = 1;
    if (cons) n_cons++;
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    fb  = exp_q.size() - int'(exp_in_en);
    ein = exp_in_en;
    if (cons) begin
      check("q_has_byte", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("byte", b, exp_q.pop_front());
      pos++;
      if (pos == BPW) begin
        pos = 0;
        exp_sent++;
      end
    end
    exp_in_en = fl ? 1'b0 : (ein && bz) ? 1'b1 : (fb > 0);
    if (fl) begin
      exp_q.delete();
      pos = 0;
    end else if (acc) begin
      for (int i = 0; i < BPW; i++)
        exp_q.push_back(d[WORD_W-1-i*BYTE_W -: BYTE_W]);
    end
    if (acc && use_src) void'(src_q.pop_front());
    check("in_en", in_en, exp_in_en);
    if (exp_in_en) check("iot_in", iot_in, exp_q[0]);
    else check("iot_zero", iot_in, 0);
    check("sent", sent_words, exp_sent[15:0]);
    check("idle", idle, exp_q.size() == 0);
    words = (exp_q.size() - int'(exp_in_en) + BPW - 1) / BPW;
    check("s_ready", s_ready, words < DEPTH);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((!idle || src_q.size() != 0) && k < maxc) begin
      cyc();
      k++;
    end
    check("drain_idle", idle, 1);
  endtask

  task automatic wait_pos(input int p, input int maxc);
    int k = 0;
    while (!(exp_in_en && pos == p) && k < maxc) begin
      cyc();
      k++;
    end
    check("reach_pos", exp_in_en && pos == p, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [15:0] snap;
    rst = 1'b0;
    flush = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    busy = 1'b0;
    use_src = 1'b0;
    mode = 0;
    base = 0;
    pulsed = -1;
    npulse = 0;
    hcnt = 0;
    cyc_no = 0;
    model_reset();
    clr_stats();
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b1;

    // single word, unthrottled
    use_src = 1'b1;
    clr_stats();
    start = cyc_no;
    src_q.push_back(W1);
    drain(100);
    check("t1_latency", first_en - start, 2);
    check("t1_en_cycles", n_en, 16);
    check("t1_sent", sent_words, 1);

    // three words back to back
    clr_stats();
    repeat (3) src_q.push_back(rnd_word());
    drain(200);
    check("t2_en_cycles", n_en, 48);
    check("t2_no_gap", last_en - first_en + 1, 48);
    check("t2_saw_full", saw_nr, 1);
    check("t2_sent", sent_words, 4);

    // hold byte 7 across five busy cycles
    clr_stats();
    mode = 1;
    hcnt = 0;
    src_q.push_back(W1);
    drain(100);
    check("t3_hold", hcnt, 5);
    check("t3_consumed", n_cons, 16);
    check("t3_sent", sent_words, 5);

    // one busy pulse per word, walking the position
    clr_stats();
    mode = 2;
    base = exp_sent;
    pulsed = -1;
    npulse = 0;
    for (int i = 0; i < BPW; i++) src_q.push_back(rnd_word());
    drain(600);
    check("t4_pulses", npulse, BPW);
    check("t4_consumed", n_cons, BPW * BPW);
    check("t4_sent", sent_words, 5 + BPW);

    // flush at byte 9 with a word queued and one offered
    mode = 0;
    src_q.push_back(rnd_word());
    src_q.push_back(rnd_word());
    wait_pos(9, 100);
    use_src = 1'b0;
    src_q.delete();
    snap = sent_words;
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = rnd_word();
    cyc();
    flush = 1'b0;
    s_valid = 1'b0;
    check("t5_in_en", in_en, 0);
    check("t5_idle", idle, 1);
    check("t5_sent", sent_words, snap);
    repeat (4) cyc();

    // asynchronous reset mid-word
    use_src = 1'b1;
    src_q.push_back(rnd_word());
    wait_pos(5, 100);
    rst = 1'b0;
    #1;
    reset_checks();
    model_reset();
    src_q.delete();
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clr_stats();
    start = cyc_no;
    src_q.push_back(W1);
    drain(100);
    check("t6_latency", first_en - start, 2);
    check("t6_en_cycles", n_en, 16);
    check("t6_sent", sent_words, 1);

    // random traffic, throttling and flushes
    use_src = 1'b0;
    mode = 3;
    for (int i = 0; i < 400; i++) begin
      s_valid = $urandom_range(0, 1) == 1;
      s_data = rnd_word();
      flush = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush = 1'b0;
    s_valid = 1'b0;
    mode = 0;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
